// File: rtl/apb_pkg.sv
// Shared types for the queued APB4 master: FSM state encoding and the
// command record carried through the command FIFO.
package apb_pkg;

    // Widest address/data/strobe a queued command can carry.
    localparam int CMD_ADDR_W = 32;
    localparam int CMD_DATA_W = 32;
    localparam int CMD_STRB_W = CMD_DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_state_t;

    typedef struct packed {
        logic                  write;
        logic [CMD_ADDR_W-1:0] addr;
        logic [CMD_DATA_W-1:0] wdata;
        logic [CMD_STRB_W-1:0] strb;
    } apb_cmd_t;

endpackage

// File: rtl/apb_master_q_if.sv
// Bundle of the command port, response port and APB fabric signals of
// apb_master_q. The master modport is the block's own view.
interface apb_master_q_if #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int NUM_SLV = 4
);
    localparam int STRB_W = DATA_W / 8;

    // command side
    logic                      cmd_valid;
    logic                      cmd_ready;
    logic                      cmd_write;
    logic [ADDR_W-1:0]         cmd_addr;
    logic [DATA_W-1:0]         cmd_wdata;
    logic [STRB_W-1:0]         cmd_strb;

    // response side
    logic                      rsp_valid;
    logic                      rsp_ready;
    logic [DATA_W-1:0]         rsp_rdata;
    logic                      rsp_slverr;
    logic                      rsp_timeout;

    // APB fabric
    logic [NUM_SLV-1:0]        PSEL;
    logic                      PENABLE;
    logic                      PWRITE;
    logic [ADDR_W-1:0]         PADDR;
    logic [DATA_W-1:0]         PWDATA;
    logic [STRB_W-1:0]         PSTRB;
    logic [NUM_SLV*DATA_W-1:0] PRDATA;
    logic [NUM_SLV-1:0]        PREADY;
    logic [NUM_SLV-1:0]        PSLVERR;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb,
        output cmd_ready,
        output rsp_valid, rsp_rdata, rsp_slverr, rsp_timeout,
        input  rsp_ready,
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb,
        input  cmd_ready,
        input  rsp_valid, rsp_rdata, rsp_slverr, rsp_timeout,
        output rsp_ready,
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
        output PRDATA, PREADY, PSLVERR
    );

endinterface

// File: rtl/apb_cmd_fifo.sv
// Synchronous first-word-fall-through FIFO. The head entry is always
// visible on rdata; pushes into a full FIFO and pops from an empty one
// are ignored.
module apb_cmd_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [WIDTH-1:0]       wdata,
    input  logic                   pop,
    output logic [WIDTH-1:0]       rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW + 1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // Entry storage; payload needs no reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers and occupancy; depth is a power of two so pointers wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/apb_master_q.sv
// Queued APB4 master. Commands are buffered in a FIFO, decoded to one
// PSEL line from an address field, and run as SETUP/ACCESS transfers with
// an optional wait-state timeout. Every command yields one response.
module apb_master_q
    import apb_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int NUM_SLV    = 4,
    parameter int SEL_LSB    = 12,
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 16
) (
    input  logic                 PCLK,
    input  logic                 PRESET,
    apb_master_q_if.master       bus
);
    localparam int STRB_W  = DATA_W / 8;
    localparam int IDX_W   = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
    localparam int CMD_W   = $bits(apb_cmd_t);
    localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;
    localparam int TO_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam int TO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam bit TO_EN   = (TIMEOUT != 0);

    // FIFO plumbing
    apb_cmd_t         cmd_in;
    apb_cmd_t         head;
    logic [CMD_W-1:0] head_bits;
    logic             push;
    logic             pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;

    // Decoded head of queue
    logic [ADDR_W-1:0]  head_addr;
    logic [DATA_W-1:0]  head_wdata;
    logic [STRB_W-1:0]  head_strb;
    logic [IDX_W-1:0]   head_idx;
    logic               head_bad;
    logic [NUM_SLV-1:0] head_onehot;

    // Transfer and response registers
    apb_state_t         state;
    logic [IDX_W-1:0]   idx_r;
    logic [TO_W-1:0]    wait_cnt;
    logic [NUM_SLV-1:0] psel_r;
    logic               penable_r;
    logic               pwrite_r;
    logic [ADDR_W-1:0]  paddr_r;
    logic [DATA_W-1:0]  pwdata_r;
    logic [STRB_W-1:0]  pstrb_r;
    logic               rsp_valid_r;
    logic [DATA_W-1:0]  rsp_rdata_r;
    logic               rsp_slverr_r;
    logic               rsp_timeout_r;

    // Selected completer's return signals
    logic [DATA_W-1:0]  prdata_sel;
    logic               pready_sel;
    logic               pslverr_sel;
    logic               timed_out;

    assign push = bus.cmd_valid && !fifo_full;
    assign pop  = (state == IDLE) && !fifo_empty;

    // Pack the incoming command into the queued record.
    always_comb begin
        cmd_in       = '0;
        cmd_in.write = bus.cmd_write;
        cmd_in.addr  = CMD_ADDR_W'(bus.cmd_addr);
        cmd_in.wdata = CMD_DATA_W'(bus.cmd_wdata);
        cmd_in.strb  = CMD_STRB_W'(bus.cmd_strb);
    end

    apb_cmd_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_cmd_fifo (
        .clk   (PCLK),
        .rst   (PRESET),
        .push  (push),
        .wdata (cmd_in),
        .pop   (pop),
        .rdata (head_bits),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign head       = apb_cmd_t'(head_bits);
    assign head_addr  = ADDR_W'(head.addr);
    assign head_wdata = DATA_W'(head.wdata);
    assign head_strb  = STRB_W'(head.strb);
    assign head_idx   = head_addr[SEL_LSB +: IDX_W];
    assign head_bad   = ({1'b0, head_idx} >= (IDX_W + 1)'(NUM_SLV));

    // One-hot select for the head command's completer.
    always_comb begin
        head_onehot = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            head_onehot[i] = (head_idx == IDX_W'(i));
        end
    end

    // Return-path mux steered only by the latched index.
    always_comb begin
        prdata_sel  = '0;
        pready_sel  = 1'b0;
        pslverr_sel = 1'b0;
        for (int i = 0; i < NUM_SLV; i++) begin
            if (idx_r == IDX_W'(i)) begin
                prdata_sel  = bus.PRDATA[i*DATA_W +: DATA_W];
                pready_sel  = bus.PREADY[i];
                pslverr_sel = bus.PSLVERR[i];
            end
        end
    end

    assign timed_out = TO_EN && (wait_cnt == TO_W'(TO_LAST));

    // Transfer FSM with registered APB and response outputs.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state         <= IDLE;
            idx_r         <= '0;
            wait_cnt      <= '0;
            psel_r        <= '0;
            penable_r     <= 1'b0;
            pwrite_r      <= 1'b0;
            paddr_r       <= '0;
            pwdata_r      <= '0;
            pstrb_r       <= '0;
            rsp_valid_r   <= 1'b0;
            rsp_rdata_r   <= '0;
            rsp_slverr_r  <= 1'b0;
            rsp_timeout_r <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        idx_r <= head_idx;
                        if (head_bad) begin
                            // No completer at this index: answer without
                            // touching the bus so PADDR etc. keep their values.
                            rsp_valid_r   <= 1'b1;
                            rsp_rdata_r   <= '0;
                            rsp_slverr_r  <= 1'b1;
                            rsp_timeout_r <= 1'b0;
                            state         <= RESP;
                        end else begin
                            psel_r   <= head_onehot;
                            pwrite_r <= head.write;
                            paddr_r  <= head_addr;
                            pwdata_r <= head_wdata;
                            pstrb_r  <= head.write ? head_strb : '0;
                            state    <= SETUP;
                        end
                    end
                end
                SETUP: begin
                    penable_r <= 1'b1;
                    wait_cnt  <= '0;
                    state     <= ACCESS;
                end
                ACCESS: begin
                    if (pready_sel) begin
                        psel_r        <= '0;
                        penable_r     <= 1'b0;
                        rsp_valid_r   <= 1'b1;
                        rsp_rdata_r   <= (!pwrite_r && !pslverr_sel) ? prdata_sel : '0;
                        rsp_slverr_r  <= pslverr_sel;
                        rsp_timeout_r <= 1'b0;
                        state         <= RESP;
                    end else if (timed_out) begin
                        psel_r        <= '0;
                        penable_r     <= 1'b0;
                        rsp_valid_r   <= 1'b1;
                        rsp_rdata_r   <= '0;
                        rsp_slverr_r  <= 1'b0;
                        rsp_timeout_r <= 1'b1;
                        state         <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_r <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.cmd_ready   = (fifo_count != CNT_W'(FIFO_DEPTH));
    assign bus.rsp_valid   = rsp_valid_r;
    assign bus.rsp_rdata   = rsp_rdata_r;
    assign bus.rsp_slverr  = rsp_slverr_r;
    assign bus.rsp_timeout = rsp_timeout_r;
    assign bus.PSEL        = psel_r;
    assign bus.PENABLE     = penable_r;
    assign bus.PWRITE      = pwrite_r;
    assign bus.PADDR       = paddr_r;
    assign bus.PWDATA      = pwdata_r;
    assign bus.PSTRB       = pstrb_r;

endmodule

// File: tb/tb_apb_master_q.sv
// Directed bench for apb_master_q: a four-completer instance with a short
// timeout, plus a three-completer instance for the decode-error path.
module tb_apb_master_q;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    apb_master_q_if #(.ADDR_W(32), .DATA_W(32), .NUM_SLV(4)) ia ();
    apb_master_q_if #(.ADDR_W(32), .DATA_W(32), .NUM_SLV(3)) ib ();

    apb_master_q #(.NUM_SLV(4), .TIMEOUT(4), .FIFO_DEPTH(4)) dut_a (
        .PCLK   (clk),
        .PRESET (rst),
        .bus    (ia.master)
    );

    apb_master_q #(.NUM_SLV(3), .TIMEOUT(4), .FIFO_DEPTH(4)) dut_b (
        .PCLK   (clk),
        .PRESET (rst),
        .bus    (ib.master)
    );

    int passed = 0;
    int total  = 0;

    // completer model controls (written by the sequence, read by the model)
    int          ws      [4];
    bit          hang    [4];
    bit          psl     [4];
    logic [31:0] rd_fixed[4];
    bit          echo;

    // model observations (written only by the model)
    int          acc_cnt     = 0;
    int          psel_cycles = 0;
    int          pen_cycles  = 0;
    int          psel_b_cycles = 0;
    logic [3:0]  pstrb_seen  = '0;
    logic [3:0]  psel_seen   = '0;

    // Completer model for dut_a: drives PREADY/PSLVERR/PRDATA mid-cycle.
    always @(negedge clk) begin
        logic [31:0] rd;
        if (ia.PSEL != 0) psel_cycles++;
        if (ib.PSEL != 0) psel_b_cycles++;
        if (ia.PENABLE) begin
            pen_cycles++;
            pstrb_seen = ia.PSTRB;
            psel_seen  = ia.PSEL;
        end
        for (int i = 0; i < 4; i++) begin
            rd = echo ? (ia.PADDR ^ 32'hFFFF_0000) : rd_fixed[i];
            ia.PRDATA[i*32 +: 32] = rd;
            ia.PREADY[i]  = ia.PSEL[i] && ia.PENABLE && !hang[i] && (acc_cnt >= ws[i]);
            ia.PSLVERR[i] = ia.PSEL[i] && ia.PENABLE && psl[i];
        end
        if (ia.PSEL != 0 && ia.PENABLE) acc_cnt++;
        else acc_cnt = 0;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_a(input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s);
        int n = 0;
        ia.cmd_write = w;
        ia.cmd_addr  = a;
        ia.cmd_wdata = d;
        ia.cmd_strb  = s;
        ia.cmd_valid = 1'b1;
        while (!ia.cmd_ready && n < 40) begin
            tick();
            n++;
        end
        chk("push accepted", 64'(ia.cmd_ready), 64'd1);
        tick();
        ia.cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp_a(input string tag);
        int n = 0;
        while (!ia.rsp_valid && n < 40) begin
            tick();
            n++;
        end
        chk({tag, " rsp_valid"}, 64'(ia.rsp_valid), 64'd1);
    endtask

    initial begin
        int n;
        int b_psel;
        int b_pen;

        for (int i = 0; i < 4; i++) begin
            ws[i] = 0; hang[i] = 1'b0; psl[i] = 1'b0;
        end
        rd_fixed[0] = 32'h0000_0A0A;
        rd_fixed[1] = 32'h1111_1111;
        rd_fixed[2] = 32'hCAFE_F00D;
        rd_fixed[3] = 32'h1234_5678;
        echo = 1'b0;
        ia.cmd_valid = 1'b0; ia.cmd_write = 1'b0; ia.cmd_addr = '0;
        ia.cmd_wdata = '0;   ia.cmd_strb  = '0;   ia.rsp_ready = 1'b0;
        ib.cmd_valid = 1'b0; ib.cmd_write = 1'b0; ib.cmd_addr = '0;
        ib.cmd_wdata = '0;   ib.cmd_strb  = '0;   ib.rsp_ready = 1'b0;
        ib.PRDATA = '0; ib.PREADY = '1; ib.PSLVERR = '0;

        // reset state
        tick(); tick();
        chk("reset cmd_ready", 64'(ia.cmd_ready), 64'd1);
        chk("reset rsp_valid", 64'(ia.rsp_valid), 64'd0);
        chk("reset PSEL", 64'(ia.PSEL), 64'd0);
        chk("reset PENABLE", 64'(ia.PENABLE), 64'd0);
        chk("reset PADDR", 64'(ia.PADDR), 64'd0);
        chk("reset PSTRB", 64'(ia.PSTRB), 64'd0);
        rst = 1'b0;
        tick();

        // zero-wait write to slave 1
        ia.rsp_ready = 1'b1;
        b_psel = psel_cycles; b_pen = pen_cycles;
        push_a(1'b1, 32'h0000_1004, 32'hDEAD_BEEF, 4'hF);
        wait_rsp_a("wr");
        chk("wr PSEL cycles", 64'(psel_cycles - b_psel), 64'd2);
        chk("wr PENABLE cycles", 64'(pen_cycles - b_pen), 64'd1);
        chk("wr PSEL value", 64'(psel_seen), 64'h2);
        chk("wr PSTRB", 64'(pstrb_seen), 64'hF);
        chk("wr PADDR held", 64'(ia.PADDR), 64'h1004);
        chk("wr PWDATA", 64'(ia.PWDATA), 64'hDEAD_BEEF);
        chk("wr PWRITE", 64'(ia.PWRITE), 64'd1);
        chk("wr slverr", 64'(ia.rsp_slverr), 64'd0);
        chk("wr timeout", 64'(ia.rsp_timeout), 64'd0);
        chk("wr rdata", 64'(ia.rsp_rdata), 64'd0);
        chk("wr PSEL in RESP", 64'(ia.PSEL), 64'd0);
        tick();
        chk("wr rsp consumed", 64'(ia.rsp_valid), 64'd0);

        // read from slave 3 with two wait states; strobes must be dropped
        ws[3] = 2;
        b_psel = psel_cycles; b_pen = pen_cycles;
        push_a(1'b0, 32'h0000_3010, 32'h0, 4'hF);
        wait_rsp_a("rd");
        chk("rd PENABLE cycles", 64'(pen_cycles - b_pen), 64'd3);
        chk("rd PSEL cycles", 64'(psel_cycles - b_psel), 64'd4);
        chk("rd PSEL value", 64'(psel_seen), 64'h8);
        chk("rd PSTRB", 64'(pstrb_seen), 64'h0);
        chk("rd rdata", 64'(ia.rsp_rdata), 64'h1234_5678);
        chk("rd slverr", 64'(ia.rsp_slverr), 64'd0);
        tick();
        ws[3] = 0;

        // completer error on a read from slave 2
        psl[2] = 1'b1;
        push_a(1'b0, 32'h0000_2000, 32'h0, 4'h0);
        wait_rsp_a("err");
        chk("err slverr", 64'(ia.rsp_slverr), 64'd1);
        chk("err rdata", 64'(ia.rsp_rdata), 64'd0);
        chk("err timeout", 64'(ia.rsp_timeout), 64'd0);
        tick();
        psl[2] = 1'b0;

        // slave 0 never ready: abort after exactly four ACCESS cycles
        hang[0] = 1'b1;
        b_pen = pen_cycles;
        push_a(1'b0, 32'h0000_0040, 32'h0, 4'h0);
        wait_rsp_a("to");
        chk("to PENABLE cycles", 64'(pen_cycles - b_pen), 64'd4);
        chk("to timeout", 64'(ia.rsp_timeout), 64'd1);
        chk("to rdata", 64'(ia.rsp_rdata), 64'd0);
        chk("to slverr", 64'(ia.rsp_slverr), 64'd0);
        tick();
        hang[0] = 1'b0;

        // five back-to-back reads with the response port stalled
        echo = 1'b1;
        ia.rsp_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            push_a(1'b0, 32'h0000_0100 + 32'(k * 4), 32'h0, 4'h0);
        end
        chk("q cmd_ready full", 64'(ia.cmd_ready), 64'd0);
        chk("q first rsp_valid", 64'(ia.rsp_valid), 64'd1);
        tick(); tick(); tick();
        chk("q rsp held", 64'(ia.rsp_valid), 64'd1);
        chk("q rdata held", 64'(ia.rsp_rdata), 64'hFFFF_0100);
        chk("q still full", 64'(ia.cmd_ready), 64'd0);
        ia.rsp_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            n = 0;
            while (!ia.rsp_valid && n < 20) begin
                tick();
                n++;
            end
            chk("q rsp order", 64'(ia.rsp_rdata), 64'hFFFF_0100 + 64'(k * 4));
            tick();
        end
        tick(); tick(); tick(); tick(); tick(); tick(); tick(); tick();
        chk("q no extra rsp", 64'(ia.rsp_valid), 64'd0);
        chk("q drained", 64'(ia.cmd_ready), 64'd1);
        echo = 1'b0;

        // decode error on the three-completer instance
        b_psel = psel_b_cycles;
        ib.cmd_write = 1'b0;
        ib.cmd_addr  = 32'h0000_3000;
        ib.cmd_valid = 1'b1;
        tick();
        ib.cmd_valid = 1'b0;
        chk("dec not yet valid", 64'(ib.rsp_valid), 64'd0);
        tick();
        chk("dec rsp_valid", 64'(ib.rsp_valid), 64'd1);
        chk("dec slverr", 64'(ib.rsp_slverr), 64'd1);
        chk("dec timeout", 64'(ib.rsp_timeout), 64'd0);
        chk("dec rdata", 64'(ib.rsp_rdata), 64'd0);
        chk("dec no PSEL", 64'(psel_b_cycles - b_psel), 64'd0);
        chk("dec PADDR kept", 64'(ib.PADDR), 64'd0);
        ib.rsp_ready = 1'b1;
        tick();
        chk("dec consumed", 64'(ib.rsp_valid), 64'd0);

        // asynchronous reset in the middle of an ACCESS phase
        hang[0] = 1'b1;
        push_a(1'b0, 32'h0000_0000, 32'h0, 4'h0);
        push_a(1'b1, 32'h0000_1008, 32'h5555_AAAA, 4'h3);
        n = 0;
        while (!ia.PENABLE && n < 20) begin
            tick();
            n++;
        end
        chk("rst reached ACCESS", 64'(ia.PENABLE), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("rst PSEL async", 64'(ia.PSEL), 64'd0);
        chk("rst PENABLE async", 64'(ia.PENABLE), 64'd0);
        chk("rst cmd_ready", 64'(ia.cmd_ready), 64'd1);
        tick();
        rst = 1'b0;
        hang[0] = 1'b0;
        b_psel = psel_cycles;
        for (int k = 0; k < 10; k++) tick();
        chk("rst no rsp", 64'(ia.rsp_valid), 64'd0);
        chk("rst queue dropped", 64'(psel_cycles - b_psel), 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
